// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the RV32I pipeline controller.
// Provides opcode constants, ImmSrc/ALUControl/ResultSrc/Forward encodings,
// branch funct3 codes and the forwarding-select helper used by hazard_unit.
package riscv_ctrl_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] BR_BEQ = 3'b000;
    localparam logic [2:0] BR_BNE = 3'b001;
    localparam logic [2:0] BR_BLT = 3'b100;
    localparam logic [2:0] BR_BGE = 3'b101;

    // Memory stage wins over Writeback; x0 is hardwired so it never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       rw_m,
        input logic       rw_w
    );
        return (rw_m && rd_m != 5'd0 && rs == rd_m) ? FWD_MEM :
               (rw_w && rd_w != 5'd0 && rs == rd_w) ? FWD_WB  : FWD_RD;
    endfunction
endpackage

// File: rtl/pipelined_controller_hazard.sv
// hazard_unit: combinational forwarding, load-use stall and flush generation.
// Inputs : D/E source registers, E/M/W destinations, ResultSrcE, RegWriteM/W, PCSrcE.
// Outputs: StallF/StallD, FlushD/FlushE, ForwardAE/ForwardBE selects.
module hazard_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int RESULTSRC_W = 2
) (
    input  logic [4:0]             i_rs1_d,
    input  logic [4:0]             i_rs2_d,
    input  logic [4:0]             i_rs1_e,
    input  logic [4:0]             i_rs2_e,
    input  logic [4:0]             i_rd_e,
    input  logic [4:0]             i_rd_m,
    input  logic [4:0]             i_rd_w,
    input  logic [RESULTSRC_W-1:0] i_result_src_e,
    input  logic                   i_reg_write_m,
    input  logic                   i_reg_write_w,
    input  logic                   i_pc_src_e,
    output logic                   o_stall_f,
    output logic                   o_stall_d,
    output logic                   o_flush_d,
    output logic                   o_flush_e,
    output logic [1:0]             o_forward_a_e,
    output logic [1:0]             o_forward_b_e
);
    logic w_lw_stall;

    // A load in E whose destination is read in D cannot be forwarded in time.
    assign w_lw_stall    = (i_result_src_e == RESULTSRC_W'(RES_MEM)) && (i_rd_e != 5'd0) &&
                           (i_rs1_d == i_rd_e || i_rs2_d == i_rd_e);
    assign o_stall_f     = w_lw_stall;
    assign o_stall_d     = w_lw_stall;
    assign o_flush_d     = i_pc_src_e;
    assign o_flush_e     = w_lw_stall | i_pc_src_e;
    assign o_forward_a_e = fwd_sel(i_rs1_e, i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w);
    assign o_forward_b_e = fwd_sel(i_rs2_e, i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w);
endmodule

// File: rtl/pipelined_controller.sv
// pipelined_controller: decode, E/M/W control pipeline and hazard control for RV32I.
// Inputs : clk, resetn (async active-low), Decode opcode fields, register
//          numbers for D/E/M/W, ZeroE/NegativeE flags from the ALU.
// Outputs: ImmSrcD, ALUControlE, ALUSrcE, MemWriteM, RegWriteW, ResultSrcW,
//          PCSrcE, stall/flush controls and forwarding selects.
module pipelined_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int RESULTSRC_W = 2,
    parameter int ALUCTRL_W   = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [6:0]             opD,
    input  logic [2:0]             funct3D,
    input  logic                   funct7b5D,
    input  logic [4:0]             Rs1D,
    input  logic [4:0]             Rs2D,
    input  logic [4:0]             Rs1E,
    input  logic [4:0]             Rs2E,
    input  logic [4:0]             RdE,
    input  logic [4:0]             RdM,
    input  logic [4:0]             RdW,
    input  logic                   ZeroE,
    input  logic                   NegativeE,
    output logic [2:0]             ImmSrcD,
    output logic [ALUCTRL_W-1:0]   ALUControlE,
    output logic                   ALUSrcE,
    output logic                   MemWriteM,
    output logic                   RegWriteW,
    output logic [RESULTSRC_W-1:0] ResultSrcW,
    output logic                   PCSrcE,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE
);
    logic                   w_reg_write_d;
    logic                   w_mem_write_d;
    logic                   w_jump_d;
    logic                   w_branch_d;
    logic                   w_alu_src_d;
    logic [RESULTSRC_W-1:0] w_result_src_d;
    logic [ALUCTRL_W-1:0]   w_alu_ctrl_d;
    logic [ALUCTRL_W-1:0]   w_alu_op;
    logic                   w_cond;

    logic                   r_reg_write_e;
    logic [RESULTSRC_W-1:0] r_result_src_e;
    logic                   r_mem_write_e;
    logic                   r_jump_e;
    logic                   r_branch_e;
    logic [ALUCTRL_W-1:0]   r_alu_ctrl_e;
    logic                   r_alu_src_e;
    logic [2:0]             r_funct3_e;
    logic                   r_reg_write_m;
    logic [RESULTSRC_W-1:0] r_result_src_m;
    logic                   r_mem_write_m;
    logic                   r_reg_write_w;
    logic [RESULTSRC_W-1:0] r_result_src_w;

    // funct7b5 only means sub for R-type; I-ALU (opD[5]=0) uses it as immediate bits.
    always_comb begin
        w_alu_op = (funct3D == 3'b000) ? ((opD[5] & funct7b5D) ? ALUCTRL_W'(ALU_SUB) : ALUCTRL_W'(ALU_ADD)) :
                   (funct3D == 3'b010) ? ALUCTRL_W'(ALU_SLT) :
                   (funct3D == 3'b110) ? ALUCTRL_W'(ALU_OR)  :
                   (funct3D == 3'b111) ? ALUCTRL_W'(ALU_AND) : ALUCTRL_W'(ALU_ADD);
    end

    always_comb begin
        w_reg_write_d  = 1'b0;
        w_mem_write_d  = 1'b0;
        w_jump_d       = 1'b0;
        w_branch_d     = 1'b0;
        w_alu_src_d    = 1'b0;
        w_result_src_d = RESULTSRC_W'(RES_ALU);
        w_alu_ctrl_d   = ALUCTRL_W'(ALU_ADD);
        ImmSrcD        = IMM_I;
        case (opD)
            OP_LOAD: begin
                w_reg_write_d  = 1'b1;
                w_alu_src_d    = 1'b1;
                w_result_src_d = RESULTSRC_W'(RES_MEM);
            end
            OP_STORE: begin
                w_mem_write_d = 1'b1;
                w_alu_src_d   = 1'b1;
                ImmSrcD       = IMM_S;
            end
            OP_RTYPE: begin
                w_reg_write_d = 1'b1;
                w_alu_ctrl_d  = w_alu_op;
            end
            OP_IALU: begin
                w_reg_write_d = 1'b1;
                w_alu_src_d   = 1'b1;
                w_alu_ctrl_d  = w_alu_op;
            end
            OP_BRANCH: begin
                w_branch_d   = 1'b1;
                w_alu_ctrl_d = ALUCTRL_W'(ALU_SUB);
                ImmSrcD      = IMM_B;
            end
            OP_JAL: begin
                w_reg_write_d  = 1'b1;
                w_jump_d       = 1'b1;
                w_result_src_d = RESULTSRC_W'(RES_PC4);
                ImmSrcD        = IMM_J;
            end
            OP_LUI: begin
                w_reg_write_d = 1'b1;
                w_alu_src_d   = 1'b1;
                w_alu_ctrl_d  = ALUCTRL_W'(ALU_PASSB);
                ImmSrcD       = IMM_U;
            end
            default: ;
        endcase
    end

    // D/E: flushed to a bubble on load-use stall or taken branch/jump.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn || FlushE) begin
            r_reg_write_e  <= 1'b0;
            r_result_src_e <= '0;
            r_mem_write_e  <= 1'b0;
            r_jump_e       <= 1'b0;
            r_branch_e     <= 1'b0;
            r_alu_ctrl_e   <= '0;
            r_alu_src_e    <= 1'b0;
            r_funct3_e     <= '0;
        end else begin
            r_reg_write_e  <= w_reg_write_d;
            r_result_src_e <= w_result_src_d;
            r_mem_write_e  <= w_mem_write_d;
            r_jump_e       <= w_jump_d;
            r_branch_e     <= w_branch_d;
            r_alu_ctrl_e   <= w_alu_ctrl_d;
            r_alu_src_e    <= w_alu_src_d;
            r_funct3_e     <= funct3D;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_reg_write_m  <= 1'b0;
            r_result_src_m <= '0;
            r_mem_write_m  <= 1'b0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= '0;
        end else begin
            r_reg_write_m  <= r_reg_write_e;
            r_result_src_m <= r_result_src_e;
            r_mem_write_m  <= r_mem_write_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
        end
    end

    always_comb begin
        w_cond = (r_funct3_e == BR_BEQ) ? ZeroE      :
                 (r_funct3_e == BR_BNE) ? !ZeroE     :
                 (r_funct3_e == BR_BLT) ? NegativeE  :
                 (r_funct3_e == BR_BGE) ? !NegativeE : 1'b0;
    end

    assign PCSrcE      = r_jump_e | (r_branch_e & w_cond);
    assign ALUControlE = r_alu_ctrl_e;
    assign ALUSrcE     = r_alu_src_e;
    assign MemWriteM   = r_mem_write_m;
    assign RegWriteW   = r_reg_write_w;
    assign ResultSrcW  = r_result_src_w;

    hazard_unit #(.RESULTSRC_W(RESULTSRC_W)) u_hazard (
        .i_rs1_d        (Rs1D),
        .i_rs2_d        (Rs2D),
        .i_rs1_e        (Rs1E),
        .i_rs2_e        (Rs2E),
        .i_rd_e         (RdE),
        .i_rd_m         (RdM),
        .i_rd_w         (RdW),
        .i_result_src_e (r_result_src_e),
        .i_reg_write_m  (r_reg_write_m),
        .i_reg_write_w  (r_reg_write_w),
        .i_pc_src_e     (PCSrcE),
        .o_stall_f      (StallF),
        .o_stall_d      (StallD),
        .o_flush_d      (FlushD),
        .o_flush_e      (FlushE),
        .o_forward_a_e  (ForwardAE),
        .o_forward_b_e  (ForwardBE)
    );
endmodule

// File: tb/tb_pipelined_controller.sv
// tb_pipelined_controller: directed and random checks against an instruction-level model.
module tb_pipelined_controller;
    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] opD;
    logic [2:0] funct3D;
    logic       funct7b5D;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ZeroE, NegativeE;
    logic [2:0] ImmSrcD, ALUControlE;
    logic       ALUSrcE, MemWriteM, RegWriteW, PCSrcE, StallF, StallD, FlushD, FlushE;
    logic [1:0] ResultSrcW, ForwardAE, ForwardBE;

    always #5 clk = ~clk;

    pipelined_controller dut (
        .clk(clk), .resetn(resetn), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ZeroE(ZeroE), .NegativeE(NegativeE), .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
    );

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       j;
        logic       b;
        logic [2:0] alu;
        logic       asrc;
        logic [2:0] f3;
        logic [2:0] imm;
    } cw_t;

    cw_t  e, m, w;
    logic exp_flush_e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control word of one instruction, straight from the instruction table.
    function automatic cw_t dec(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        cw_t        c;
        logic [2:0] aop;
        c = '0;
        aop = (f3 == 3'd0) ? ((op == 7'h33 && f7) ? 3'd1 : 3'd0) :
              (f3 == 3'd2) ? 3'd5 : (f3 == 3'd6) ? 3'd3 : (f3 == 3'd7) ? 3'd2 : 3'd0;
        case (op)
            7'h03: begin c.rw = 1; c.asrc = 1; c.rs = 2'd1; end
            7'h23: begin c.mw = 1; c.asrc = 1; c.imm = 3'd1; end
            7'h33: begin c.rw = 1; c.alu = aop; end
            7'h13: begin c.rw = 1; c.asrc = 1; c.alu = aop; end
            7'h63: begin c.b = 1; c.imm = 3'd2; c.alu = 3'd1; end
            7'h6F: begin c.rw = 1; c.j = 1; c.imm = 3'd3; c.rs = 2'd2; end
            7'h37: begin c.rw = 1; c.asrc = 1; c.imm = 3'd4; c.alu = 3'd7; end
            default: ;
        endcase
        c.f3 = f3;
        return c;
    endfunction

    // Drive one cycle's inputs, then compare every output against the model at the falling edge.
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] r1d, input logic [4:0] r2d, input logic [4:0] r1e,
                        input logic [4:0] r2e, input logic [4:0] rde, input logic [4:0] rdm,
                        input logic [4:0] rdw, input logic z, input logic ng);
        logic       taken, pcs, lws;
        logic [1:0] fa, fb;
        opD = op; funct3D = f3; funct7b5D = f7;
        Rs1D = r1d; Rs2D = r2d; Rs1E = r1e; Rs2E = r2e; RdE = rde; RdM = rdm; RdW = rdw;
        ZeroE = z; NegativeE = ng;
        @(negedge clk);
        case (e.f3)
            3'd0: taken = z;
            3'd1: taken = !z;
            3'd4: taken = ng;
            3'd5: taken = !ng;
            default: taken = 1'b0;
        endcase
        pcs = e.j | (e.b & taken);
        lws = (e.rs == 2'd1) && (rde != 0) && (r1d == rde || r2d == rde);
        fa = (m.rw && rdm != 0 && r1e == rdm) ? 2'd2 : (w.rw && rdw != 0 && r1e == rdw) ? 2'd1 : 2'd0;
        fb = (m.rw && rdm != 0 && r2e == rdm) ? 2'd2 : (w.rw && rdw != 0 && r2e == rdw) ? 2'd1 : 2'd0;
        exp_flush_e = lws | pcs;
        chk("ImmSrcD", ImmSrcD, dec(op, f3, f7).imm);
        chk("ALUControlE", ALUControlE, e.alu);
        chk("ALUSrcE", ALUSrcE, e.asrc);
        chk("MemWriteM", MemWriteM, m.mw);
        chk("RegWriteW", RegWriteW, w.rw);
        chk("ResultSrcW", ResultSrcW, w.rs);
        chk("PCSrcE", PCSrcE, pcs);
        chk("StallF", StallF, lws);
        chk("StallD", StallD, lws);
        chk("FlushD", FlushD, pcs);
        chk("FlushE", FlushE, lws | pcs);
        chk("ForwardAE", ForwardAE, fa);
        chk("ForwardBE", ForwardBE, fb);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!resetn) begin
            e = '0; m = '0; w = '0;
        end else begin
            w = m;
            m = e;
            e = exp_flush_e ? '0 : dec(opD, funct3D, funct7b5D);
        end
        #1;
    endtask

    initial begin
        logic [6:0] ops [8];
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
        ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h37; ops[7] = 7'h7F;
        e = '0; m = '0; w = '0; exp_flush_e = 1'b0;
        resetn = 1'b0;
        step(7'h33, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0);
        tick();
        resetn = 1'b1;

        // add x3,x1,x2 ; sub x4,x3,x1
        step(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        step(7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd1, 5'd4, 5'd3, 5'd0, 1'b0, 1'b0);
        chk("sub_fwdA", ForwardAE, 2'b10);
        chk("sub_alu", ALUControlE, 3'b001);
        tick();

        // lw x5,0(x0) ; add x6,x5,x5
        step(7'h03, 3'd2, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        step(7'h33, 3'd0, 1'b0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd5, 5'd4, 5'd0, 1'b0, 1'b0);
        chk("lw_stallF", StallF, 1'b1);
        chk("lw_stallD", StallD, 1'b1);
        chk("lw_flushE", FlushE, 1'b1);
        tick();
        step(7'h33, 3'd0, 1'b0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd4, 1'b0, 1'b0);
        chk("lw_nostall", StallF, 1'b0);
        tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 5'd5, 5'd6, 5'd0, 5'd5, 1'b0, 1'b0);
        chk("lw_fwdA", ForwardAE, 2'b01);
        chk("lw_fwdB", ForwardBE, 2'b01);
        chk("lw_ressrcW", ResultSrcW, 2'b01);
        tick();

        // beq taken, then beq not taken
        step(7'h63, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        step(7'h13, 3'd6, 1'b0, 5'd1, 5'd0, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("beq_pcsrc", PCSrcE, 1'b1);
        chk("beq_flushD", FlushD, 1'b1);
        chk("beq_flushE", FlushE, 1'b1);
        tick();
        step(7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("beq_bubble_alu", ALUControlE, 3'b000);
        chk("beq_bubble_src", ALUSrcE, 1'b0);
        tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("bne_pcsrc", PCSrcE, 1'b0);
        chk("bne_flushD", FlushD, 1'b0);
        chk("bne_flushE", FlushE, 1'b0);
        tick();

        // jal x1
        step(7'h6F, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("jal_pcsrc", PCSrcE, 1'b1);
        tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0); tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
        chk("jal_ressrcW", ResultSrcW, 2'b10);
        chk("jal_regwW", RegWriteW, 1'b1);
        tick();

        // lw x0 followed by a reader of x0; then illegal opcode 0x7F
        step(7'h03, 3'd2, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        step(7'h33, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("x0_nostall", StallF, 1'b0);
        tick();
        step(7'h7F, 3'd7, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("x0_fwdA", ForwardAE, 2'b00);
        chk("bad_imm", ImmSrcD, 3'b000);
        tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("bad_alu", ALUControlE, 3'b000);
        chk("bad_pcsrc", PCSrcE, 1'b0);
        tick();

        // sw reaches M, reset drops MemWriteM before the next edge, then refill with lui
        step(7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("sw_memwM", MemWriteM, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_memwM", MemWriteM, 1'b0);
        chk("rst_regwW", RegWriteW, 1'b0);
        e = '0; m = '0; w = '0;
        tick();
        resetn = 1'b1;
        step(7'h37, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("refill_empty", ALUControlE, 3'b000);
        tick();
        step(7'h13, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("refill_alu", ALUControlE, 3'b111);
        chk("refill_src", ALUSrcE, 1'b1);
        tick();

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Control and hazard block that feeds the five-stage RV32I datapath.
- Decodes the Decode-stage opcode fields and carries the resulting control word through E/M/W pipeline registers.
- Resolves branches and jumps in Execute.
- Generates stall, flush and forwarding selects for the datapath.

Parameters:
- RESULTSRC_W, 2, width of the writeback result select.
- ALUCTRL_W, 3, width of the ALU operation code.

Ports:
- clk  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- opD  in  7  InstrD[6:0].
- funct3D  in  3  InstrD[14:12].
- funct7b5D  in  1  InstrD[30].
- Rs1D  in  5  source register 1 in Decode.
- Rs2D  in  5  source register 2 in Decode.
- Rs1E  in  5  source register 1 in Execute.
- Rs2E  in  5  source register 2 in Execute.
- RdE  in  5  destination register in Execute.
- RdM  in  5  destination register in Memory.
- RdW  in  5  destination register in Writeback.
- ZeroE  in  1  ALU result == 0.
- NegativeE  in  1  ALU result negative.
- ImmSrcD  out  3  immediate format: I=000, S=001, B=010, J=011, U=100.
- ALUControlE  out  3  add=000, sub=001, and=010, or=011, slt=101, passB=111.
- ALUSrcE  out  1  1 selects ImmExtE as SrcB.
- MemWriteM  out  1  data memory write enable.
- RegWriteW  out  1  register file write enable.
- ResultSrcW  out  2  00 = ALU result, 01 = memory read data, 10 = PC+4.
- PCSrcE  out  1  1 selects PCTargetE.
- StallF  out  1  hold the PC register.
- StallD  out  1  hold the F/D pipeline register.
- FlushD  out  1  clear the F/D pipeline register.
- FlushE  out  1  clear the D/E pipeline register.
- ForwardAE  out  2  00 = RD1E, 01 = ResultW, 10 = ALUResultM.
- ForwardBE  out  2  same encoding as ForwardAE, applied to RD2E.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (resetn). While resetn=0, all pipeline control registers are 0. Registered outputs (ALUControlE, ALUSrcE, MemWriteM, RegWriteW, ResultSrcW) therefore read 0, and the combinational outputs evaluate from those zeros.
- Decode is combinational in D:
  - lw 0000011: RegWrite=1, ImmSrc=I, ALUSrc=1, ResultSrc=01, ALU=add.
  - sw 0100011: MemWrite=1, ImmSrc=S, ALUSrc=1, ALU=add.
  - R-type 0110011: RegWrite=1, ALUSrc=0.
  - I-ALU 0010011: RegWrite=1, ImmSrc=I, ALUSrc=1.
  - branch 1100011: Branch=1, ImmSrc=B, ALU=sub.
  - jal 1101111: RegWrite=1, Jump=1, ImmSrc=J, ResultSrc=10.
  - lui 0110111: RegWrite=1, ImmSrc=U, ALUSrc=1, ALU=passB.
  - Any other opcode produces an all-zero control word (bubble).
- ALU op for R-type and I-ALU, selected by funct3:
  - 000: sub if (opD[5] & funct7b5D), else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Other funct3 values give add.
- D/E register: holds RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc and funct3. It is synchronously cleared to 0 when FlushE=1 at the clock edge.
- E/M register: holds RegWrite, ResultSrc, MemWrite.
- M/W register: holds RegWrite, ResultSrc.
- E/M and M/W are never stalled or flushed.
- Latency: a control word appears on the E outputs 1 cycle after D, on M after 2 cycles, on W after 3 cycles.
- Branch condition in E, by funct3E:
  - 000 taken if ZeroE.
  - 001 taken if !ZeroE.
  - 100 taken if NegativeE.
  - 101 taken if !NegativeE.
  - Any other funct3 is not taken.
- PCSrcE = JumpE | (BranchE & cond).
- Load-use stall: lwStall = (ResultSrcE==01) & (RdE!=0) & (Rs1D==RdE | Rs2D==RdE). StallF = StallD = lwStall.
- Flushes: FlushD = PCSrcE. FlushE = lwStall | PCSrcE.
- If lwStall and PCSrcE are both high, both flush conditions apply; the taken branch wins because D is flushed and E is bubbled.
- ForwardAE:
  - 10 if RegWriteM & RdM!=0 & Rs1E==RdM.
  - Otherwise 01 if RegWriteW & RdW!=0 & Rs1E==RdW.
  - Otherwise 00.
  - M has priority when both M and W match.
- ForwardBE follows the same rules using Rs2E.
- x0 never forwards and never stalls.
- Reset asserted mid-operation discards all in-flight control words immediately. The first instruction after release appears in E one cycle later.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - ImmSrc, ALUControl, ResultSrc and Forward encodings;
  - branch funct3 codes.
- One combinational sub-module, hazard_unit, computes the forwarding selects, lwStall, the stalls and the flushes.
- Decode logic and the pipeline registers stay in pipelined_controller.

Test Plan:
- add x3,x1,x2 followed by sub x4,x3,x1 → in the sub's E cycle, ForwardAE=10 and ALUControlE=001.
- lw x5,0(x0) followed by add x6,x5,x5 → lwStall for 1 cycle (StallF=StallD=FlushE=1). Next cycle ForwardAE=ForwardBE=01, and ResultSrcW=01 when the lw is in W.
- beq with ZeroE=1 → PCSrcE=1, FlushD=1, FlushE=1, and the next E control word is all zero. With ZeroE=0 → PCSrcE=0 and no flush.
- jal x1,imm → PCSrcE=1 in E; 3 cycles after D, ResultSrcW=10 and RegWriteW=1.
- An instruction writing x0 followed by a reader of x0 → ForwardAE=00 and no stall. Opcode 0x7F → all controls 0.
- Assert resetn=0 with sw in M → MemWriteM drops to 0 asynchronously, before the next edge. After release, the pipeline refills correctly.
